// File: rtl/uart_tx_mmio_if.sv
// CPU store/load bus seen by the memory-mapped UART transmitter.
// The CPU drives the store triple; the UART returns the status word to the load mux.
interface uart_tx_mmio_if;
    logic       we;
    logic [7:0] Address;
    logic [7:0] RegData;
    logic [7:0] RdData;
    logic       RdHit;

    modport master (output we, Address, RegData, input RdData, RdHit);
    modport slave  (input we, Address, RegData, output RdData, RdHit);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a pollable status word.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
//
// state  | meaning
// IDLE   | line high; pops the FIFO into the shifter when a byte is waiting
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | eight data bits, LSB first, CLKS_PER_BIT cycles each
// PARITY | even parity of the byte (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_mmio #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] TX_ADDR      = 8'hFE,
    parameter logic [7:0] STATUS_ADDR  = 8'hFD
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_mmio_if.slave  bus,
    output logic           tx,
    output logic           busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state;
    logic            we_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            overflow;
    logic [7:0]      shreg;
    logic [2:0]      bitcnt;
    logic [BW-1:0]   baudcnt;
`ifdef UART_TX_PARITY_EN
    logic            par_bit;
`endif

    logic push, pop, push_ok, full, empty, baud_done;
    logic [7:0] status;

    // Rising edge of we gives one push per store however long the CPU holds it.
    assign push      = bus.we & ~we_q & (bus.Address == TX_ADDR);
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign pop       = (state == S_IDLE) && !empty;
    assign push_ok   = push && (!full || pop);
    assign baud_done = (baudcnt == BAUD_LAST);

    assign busy       = (state != S_IDLE) || !empty;
    assign status     = {5'b0, overflow, full, busy};
    assign bus.RdHit  = (bus.Address == STATUS_ADDR);
    assign bus.RdData = bus.RdHit ? status : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.RegData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            we_q <= bus.we;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok)
                overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            bitcnt  <= '0;
            baudcnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (state != S_IDLE)
                baudcnt <= baud_done ? '0 : baudcnt + 1'b1;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^mem[rd_ptr];
`endif
                        bitcnt  <= '0;
                        baudcnt <= '0;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        tx    <= shreg[0];
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par_bit;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            shreg  <= shreg >> 1;
                            bitcnt <= bitcnt + 1'b1;
                            tx     <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done)
                        state <= S_IDLE;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a timing-level FIFO/line model predicts each frame
// and its start cycle; a line monitor decodes tx and checks against the queue.
module tb_uart_tx_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME  = NBITS * CPB;
    localparam int PERIOD = FRAME + 1;
    localparam logic [7:0] TXA = 8'hFE;
    localparam logic [7:0] STA = 8'hFD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (TXA),
        .STATUS_ADDR  (STA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         pop;
    } exp_t;

    exp_t exp_q[$];
    int   sched[$];
    int   last_pop = -100000;
    bit   ovf_m = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   rx_active = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Bytes accepted but not yet popped after edge c.
    function automatic int occupancy(int c);
        int n = 0;
        foreach (sched[i]) if (sched[i] > c) n++;
        return n;
    endfunction

    function automatic logic [7:0] model_status(int c);
        int cnt = occupancy(c);
        bit b = (cnt > 0);
        foreach (sched[i]) if (sched[i] <= c && c < sched[i] + FRAME) b = 1'b1;
        return {5'b0, ovf_m, (cnt == DEPTH), b};
    endfunction

    // A byte stored at edge c starts its frame at the first edge after c where the line is free.
    function automatic void model_push(int c, logic [7:0] d);
        int p;
        if (occupancy(c) >= DEPTH) begin
            ovf_m = 1'b1;
        end else begin
            p = c + 1;
            if (last_pop + PERIOD > p) p = last_pop + PERIOD;
            sched.push_back(p);
            exp_q.push_back('{data: d, pop: p});
            last_pop = p;
        end
    endfunction

    initial begin : monitor
        exp_t             cur;
        int               off;
        logic [NBITS-1:0] bits;
        bit               bad;
        logic [7:0]       rxb;
        off = 0;
        bits = '1;
        bad = 1'b0;
        rxb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_active = 1'b0;
            end else begin
                if (!rx_active && tx == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_frame: start bit seen at cycle %0d, required idle line", cyc);
                        cur = '{data: 8'h00, pop: cyc};
                    end else begin
                        cur = exp_q.pop_front();
                        check("frame_start_cycle", 32'(cyc), 32'(cur.pop));
                    end
                    bits = '1;
                    bits[0] = 1'b0;
                    bits[8:1] = cur.data;
`ifdef UART_TX_PARITY_EN
                    bits[9] = ^cur.data;
`endif
                    off = 0;
                    bad = 1'b0;
                    rxb = '0;
                    rx_active = 1'b1;
                end
                if (rx_active) begin
                    if (tx !== bits[off / CPB]) bad = 1'b1;
                    if ((off % CPB) == CPB / 2 && off / CPB >= 1 && off / CPB <= 8)
                        rxb[off / CPB - 1] = tx;
                    off++;
                    if (off == FRAME) begin
                        rx_active = 1'b0;
                        check("frame_data", 32'({bad, rxb}), 32'({1'b0, cur.data}));
                    end
                end
            end
        end
    end

    task automatic store(input logic [7:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        bus.Address = a;
        bus.RegData = d;
        bus.we = 1'b1;
        if (a == TXA) model_push(cyc + 1, d);
        repeat (hold) @(negedge clk);
        bus.we = 1'b0;
        bus.Address = 8'h00;
    endtask

    task automatic store_at(input int edge_c, input logic [7:0] d);
        while (cyc < edge_c - 1) @(negedge clk);
        bus.Address = TXA;
        bus.RegData = d;
        bus.we = 1'b1;
        model_push(cyc + 1, d);
        @(negedge clk);
        bus.we = 1'b0;
        bus.Address = 8'h00;
    endtask

    task automatic check_status(input string name);
        @(negedge clk);
        bus.Address = STA;
        #1;
        check(name, 32'(bus.RdData), 32'(model_status(cyc)));
        check("status_hit", 32'(bus.RdHit), 32'd1);
        bus.Address = 8'h00;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.we = 1'b0;
        exp_q.delete();
        sched.delete();
        last_pop = -100000;
        ovf_m = 1'b0;
        #1;
        check("tx_async_reset", 32'(tx), 32'd1);
        check("busy_async_reset", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || rx_active) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 32'(exp_q.size() + int'(rx_active)), 32'd0);
        repeat (PERIOD) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : stimulus
        logic [7:0] a;
        int p0;
        bus.we = 1'b0;
        bus.Address = 8'h00;
        bus.RegData = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        repeat (10) @(negedge clk);
        check("tx_idle", 32'(tx), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        bus.Address = STA;
        #1;
        check("status_reset", 32'(bus.RdData), 32'h00);
        check("hit_status_addr", 32'(bus.RdHit), 32'd1);
        bus.Address = 8'h12;
        #1;
        check("rddata_other_addr", 32'(bus.RdData), 32'h00);
        check("hit_other_addr", 32'(bus.RdHit), 32'd0);

        // Single store with long we hold: one frame
        store(TXA, 8'hA5, 20);
        wait_drain();
        check_status("status_after_single");

        // Stores to other addresses push nothing
        store(8'h10, 8'h3C, 2);
        store(STA, 8'h55, 3);
        repeat (PERIOD) @(negedge clk);

        // Six back-to-back stores: one in flight, four queued, one dropped
        for (int i = 0; i < 6; i++) store(TXA, 8'($urandom), 1);
        check_status("status_overflow_model");
        bus.Address = STA;
        #1;
        check("status_07", 32'(bus.RdData), 32'h07);
        bus.Address = 8'h00;
        wait_drain();
        check_status("status_overflow_sticky");

        // Push while full on the edge where IDLE pops
        @(negedge clk);
        #1;
        apply_reset();
        for (int i = 0; i < 5; i++) store(TXA, 8'($urandom), 1);
        store_at(sched[1], 8'hC3);
        bus.Address = STA;
        #1;
        check("status_push_on_pop", 32'(bus.RdData), 32'h03);
        bus.Address = 8'h00;
        check_status("status_push_on_pop_model");
        wait_drain();

        // Reset during data bit 3
        for (int i = 0; i < 3; i++) store(TXA, 8'($urandom), 1);
        p0 = sched[sched.size() - 3];
        while (cyc < p0 + 17) @(negedge clk);
        #1;
        apply_reset();
        check_status("status_after_midframe_reset");
        check("busy_after_midframe_reset", 32'(busy), 32'd0);
        repeat (2 * PERIOD) @(negedge clk);

        // Randomized stores
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) a = STA;
            else if ($urandom_range(0, 9) == 0) a = 8'($urandom);
            else a = TXA;
            store(a, 8'($urandom), $urandom_range(1, 4));
            repeat ($urandom_range(0, 50)) @(negedge clk);
            if (i % 5 == 4) check_status("status_random");
        end
        wait_drain();
        check_status("status_random_end");

`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        #1;
        apply_reset();
        store(TXA, 8'h07, 1);
        wait_drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
